// File: rtl/uart_rx_axis.sv
// rtl/uart_rx_axis.sv - 16x oversampled UART receiver with frame FIFO and AXIS output
module uart_rx_axis #(
   parameter int DATA_BITS  = 8,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rx,
   input  logic [DIV_W-1:0]                cfg_div,
   input  logic [1:0]                      cfg_parity,
   input  logic                            cfg_two_stop,
   output logic [DATA_BITS-1:0]            m_axis_tdata,
   output logic [1:0]                      m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            overrun,
   output logic                            break_det,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int EW = DATA_BITS + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_meta_q, rx_s_q, rx_prev_q;
   logic [1:0]           sync_vld_q;
   logic                 armed_q;
   logic [DIV_W-1:0]     div_q, cnt_q, div_m1;
   logic [1:0]           par_q;
   logic                 two_q;
   logic [3:0]           tcnt_q;
   logic                 s7_q, s8_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 par_err_q, par_bit_q, stop1_q;

   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [AW:0]          wr_q, rd_q;

   logic tick, t9, t15, start, maj, par_en, is_brk, fe_now, complete;
   logic full, empty, pop, push_req, do_push;

   assign div_m1 = (div_q == '0) ? '0 : div_q - 1'b1;
   assign tick   = (cnt_q == div_m1);
   assign t9     = tick && (tcnt_q == 4'd9);
   assign t15    = tick && (tcnt_q == 4'd15);
   assign start  = (state_q == S_IDLE) && armed_q && rx_prev_q && !rx_s_q;
   assign maj    = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
   assign par_en = (par_q == 2'b01) || (par_q == 2'b10);

   // In STOP1 the stop bit is being resolved now; in STOP2 it was stored earlier.
   assign is_brk = (data_q == '0) && !(par_en && par_bit_q) &&
                   !((state_q == S_STOP1) ? maj : stop1_q);
   assign fe_now = (state_q == S_STOP1) ? !maj : (!stop1_q || !maj);

   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      case (state_q)
         S_IDLE:   if (start) state_d = S_START;
         S_START: begin
            if (t9 && maj)  state_d = S_IDLE;
            else if (t15)   state_d = S_DATA;
         end
         S_DATA:   if (t15 && bit_cnt_q == BW'(DATA_BITS))
                      state_d = par_en ? S_PARITY : S_STOP1;
         S_PARITY: if (t15) state_d = S_STOP1;
         S_STOP1: begin
            if (t9 && !two_q)     complete = 1'b1;
            else if (t15 && two_q) state_d = S_STOP2;
         end
         S_STOP2:  if (t9) complete = 1'b1;
         S_BRK:    if (rx_s_q) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (complete) state_d = is_brk ? S_BRK : S_IDLE;
   end

   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop      = !empty && m_axis_tready;
   assign push_req = complete && !is_brk;
   assign do_push  = push_req && (!full || pop);

   assign overrun   = push_req && full && !pop;
   assign break_det = complete && is_brk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_prev_q  <= 1'b1;
         sync_vld_q <= '0;
         armed_q    <= 1'b0;
         div_q      <= '0;
         cnt_q      <= '0;
         par_q      <= '0;
         two_q      <= 1'b0;
         tcnt_q     <= '0;
         s7_q       <= 1'b1;
         s8_q       <= 1'b1;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_err_q  <= 1'b0;
         par_bit_q  <= 1'b0;
         stop1_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx;
         rx_s_q     <= rx_meta_q;
         rx_prev_q  <= rx_s_q;
         sync_vld_q <= {sync_vld_q[0], 1'b1};
         // Only trust rx_s once the synchroniser holds real samples, not reset values.
         if (sync_vld_q[1] && rx_s_q) armed_q <= 1'b1;

         if (start) begin
            div_q     <= cfg_div;
            par_q     <= cfg_parity;
            two_q     <= cfg_two_stop;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            par_bit_q <= 1'b0;
            stop1_q   <= 1'b1;
         end else if (tick) begin
            cnt_q  <= '0;
            tcnt_q <= tcnt_q + 1'b1;
         end else begin
            cnt_q  <= cnt_q + 1'b1;
         end

         if (tick && tcnt_q == 4'd7) s7_q <= rx_s_q;
         if (tick && tcnt_q == 4'd8) s8_q <= rx_s_q;

         if (t9) begin
            case (state_q)
               S_DATA: begin
                  data_q    <= {maj, data_q[DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
               S_PARITY: begin
                  par_bit_q <= maj;
                  par_err_q <= (^data_q) ^ maj ^ par_q[1];
               end
               S_STOP1: stop1_q <= maj;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (pop)     rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= {fe_now, par_err_q, data_q};
   end

   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = empty ? '0 : mem[rd_q[AW-1:0]][DATA_BITS-1:0];
   assign m_axis_tuser  = empty ? '0 : mem[rd_q[AW-1:0]][EW-1:DATA_BITS];
   assign fifo_level    = wr_q - rd_q;

endmodule
